// File: rtl/comparador_serial_msb_pkg.sv
// Shared types and defaults for the bit-serial MSB-first magnitude comparator.
// State encodings are fixed so that traces stay comparable with older dumps.
package comparador_serial_msb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int unsigned N_DEFAULT     = 4;
    localparam int unsigned CNT_W_DEFAULT = 3;

endpackage

// File: rtl/comparador_serial_msb_if.sv
// Operand/result bundle between the serial operand source (master) and the
// comparator (slave).
interface comparador_serial_msb_if;

    logic start;
    logic bit_valid;
    logic bit_x;
    logic bit_y;
    logic busy;
    logic done;
    logic mayor;
    logic igual;
    logic menor;

    modport master (
        output start, bit_valid, bit_x, bit_y,
        input  busy, done, mayor, igual, menor
    );

    modport slave (
        input  start, bit_valid, bit_x, bit_y,
        output busy, done, mayor, igual, menor
    );

endinterface

// File: rtl/comparador_serial_msb_bit.sv
// One-bit comparison cell from gate primitives: gt = x & ~y, lt = ~x & y.
module comparador_bit (
    input  logic x,
    input  logic y,
    output logic gt,
    output logic lt
);

    logic w_nx;
    logic w_ny;

    not u_nx (w_nx, x);
    not u_ny (w_ny, y);
    and u_gt (gt, x, w_ny);
    and u_lt (lt, w_nx, y);

endmodule

// File: rtl/comparador_serial_msb.sv
// Bit-serial MSB-first magnitude comparator with mayor/igual/menor result flags.
// Optional macro EARLY_EXIT_EN: finish on the first differing bit pair.
module comparador_serial_msb
    import comparador_serial_msb_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input logic                    clk,
    input logic                    rst,
    comparador_serial_msb_if.slave bus
);

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             r_decided, w_decided_nx;
    logic             r_gt, w_gt_nx;
    logic             r_lt, w_lt_nx;
    logic             r_mayor, w_mayor_nx;
    logic             r_igual, w_igual_nx;
    logic             r_menor, w_menor_nx;
    logic             w_bit_gt, w_bit_lt;
    logic             w_last;

    comparador_bit u_bit (
        .x  (bus.bit_x),
        .y  (bus.bit_y),
        .gt (w_bit_gt),
        .lt (w_bit_lt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_mayor   <= 1'b0;
            r_igual   <= 1'b0;
            r_menor   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_decided <= w_decided_nx;
            r_gt      <= w_gt_nx;
            r_lt      <= w_lt_nx;
            r_mayor   <= w_mayor_nx;
            r_igual   <= w_igual_nx;
            r_menor   <= w_menor_nx;
        end
    end

    // The decision is tracked in r_gt/r_lt and only copied to the visible
    // flags on entry to DONE, so the flags stay low throughout SHIFT.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_decided_nx = r_decided;
        w_gt_nx      = r_gt;
        w_lt_nx      = r_lt;
        w_mayor_nx   = r_mayor;
        w_igual_nx   = r_igual;
        w_menor_nx   = r_menor;
        w_last       = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_nx   = SHIFT;
                    w_cnt_nx     = '0;
                    w_decided_nx = 1'b0;
                    w_gt_nx      = 1'b0;
                    w_lt_nx      = 1'b0;
                    w_mayor_nx   = 1'b0;
                    w_igual_nx   = 1'b0;
                    w_menor_nx   = 1'b0;
                end else if (r_state == DONE) begin
                    w_state_nx = IDLE;
                end
            end
            SHIFT: begin
                if (bus.bit_valid) begin
                    w_cnt_nx = r_cnt + 1'b1;
                    if (!r_decided && (w_bit_gt || w_bit_lt)) begin
                        w_decided_nx = 1'b1;
                        w_gt_nx      = w_bit_gt;
                        w_lt_nx      = w_bit_lt;
                    end
`ifdef EARLY_EXIT_EN
                    w_last = (r_cnt == CNT_W'(N - 1)) || w_decided_nx;
`else
                    w_last = (r_cnt == CNT_W'(N - 1));
`endif
                    if (w_last) begin
                        w_state_nx = DONE;
                        w_mayor_nx = w_gt_nx;
                        w_menor_nx = w_lt_nx;
                        w_igual_nx = !w_decided_nx;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign bus.busy  = (r_state == SHIFT);
    assign bus.done  = (r_state == DONE);
    assign bus.mayor = r_mayor;
    assign bus.igual = r_igual;
    assign bus.menor = r_menor;

endmodule

// File: tb/tb_comparador_serial_msb.sv
// Self-checking bench for comparador_serial_msb: expected results are queued
// at stimulus time and matched against done pulses captured by a monitor.
`timescale 1ns/1ps
module tb_comparador_serial_msb;

    localparam int unsigned N = 4;
`ifdef EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        int unsigned cyc;
        logic        mayor;
        logic        igual;
        logic        menor;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    res_t        exp_q[$];
    res_t        obs_q[$];
    int unsigned done_run = 0;
    int unsigned max_run = 0;

    comparador_serial_msb_if bus ();

    comparador_serial_msb #(.N(N), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        res_t r;
        if (!rst && bus.done === 1'b1) begin
            r.cyc   = cyc;
            r.mayor = bus.mayor;
            r.igual = bus.igual;
            r.menor = bus.menor;
            obs_q.push_back(r);
            done_run = done_run + 1;
            if (done_run > max_run) max_run = done_run;
        end else begin
            done_run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    // Reference: numeric compare for flags; done cycle from slot walk.
    function automatic res_t model(input logic [3:0] x, input logic [3:0] y,
                                   input logic [7:0] stalls, input int unsigned t);
        res_t        r;
        int unsigned slot = 0;
        int unsigned k = 0;
        int unsigned last_slot = 0;
        bit          stop = 1'b0;
        r.mayor = (x > y);
        r.igual = (x == y);
        r.menor = (x < y);
        while (k < N && !stop && slot < 8) begin
            if (!stalls[slot]) begin
                last_slot = slot;
                if (EARLY && (x[N-1-k] != y[N-1-k])) stop = 1'b1;
                k++;
            end
            slot++;
        end
        r.cyc = t + last_slot + 2;
        return r;
    endfunction

    task automatic drive_cmp(input logic [3:0] x, input logic [3:0] y, input logic [7:0] stalls);
        int unsigned k = 0;
        int unsigned slot = 0;
        bus.start = 1'b1;
        exp_q.push_back(model(x, y, stalls, cyc));
        @(negedge clk);
        bus.start = 1'b0;
        while (k < N && slot < 8) begin
            if (stalls[slot]) begin
                bus.bit_valid = 1'b0;
            end else begin
                bus.bit_valid = 1'b1;
                bus.bit_x     = x[N-1-k];
                bus.bit_y     = y[N-1-k];
                k++;
            end
            slot++;
            @(negedge clk);
            if (bus.busy !== 1'b1) break;
        end
        bus.bit_valid = 1'b0;
    endtask

    task automatic fetch(output bit got, output res_t e, output res_t o);
        int unsigned g = 0;
        while (obs_q.size() == 0 && g < 30) begin
            @(negedge clk);
            g++;
        end
        got = (obs_q.size() != 0);
        e = exp_q.pop_front();
        if (got) begin
            o = obs_q.pop_front();
        end else begin
            o.cyc = 0; o.mayor = 1'b0; o.igual = 1'b0; o.menor = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_cycles(2);
        checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.mayor !== 1'b0) begin errors++; $display("FAIL reset_mayor got %b want 0", bus.mayor); end
        checks++; if (bus.igual !== 1'b0) begin errors++; $display("FAIL reset_igual got %b want 0", bus.igual); end
        checks++; if (bus.menor !== 1'b0) begin errors++; $display("FAIL reset_menor got %b want 0", bus.menor); end
        rst = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_greater;
        bit got; res_t e, o;
        drive_cmp(4'b1010, 4'b1001, 8'h00);
        fetch(got, e, o);
        checks++; if (!got) begin errors++; $display("FAIL gt_timeout got no done want done"); end
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL gt_latency got cyc %0d want %0d", o.cyc, e.cyc); end
        checks++; if ({o.mayor, o.igual, o.menor} !== {e.mayor, e.igual, e.menor})
            begin errors++; $display("FAIL gt_flags got %b%b%b want %b%b%b", o.mayor, o.igual, o.menor, e.mayor, e.igual, e.menor); end
        idle_cycles(3);
        checks++; if ({bus.mayor, bus.igual, bus.menor} !== 3'b100)
            begin errors++; $display("FAIL gt_hold got %b%b%b want 100", bus.mayor, bus.igual, bus.menor); end
        checks++; if ({bus.busy, bus.done} !== 2'b00)
            begin errors++; $display("FAIL gt_idle busy/done got %b%b want 00", bus.busy, bus.done); end
    endtask

    task automatic test_equal;
        bit got; res_t e, o;
        drive_cmp(4'b0110, 4'b0110, 8'h00);
        fetch(got, e, o);
        checks++; if (!got) begin errors++; $display("FAIL eq_timeout got no done want done"); end
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL eq_latency got cyc %0d want %0d", o.cyc, e.cyc); end
        checks++; if ({o.mayor, o.igual, o.menor} !== 3'b010)
            begin errors++; $display("FAIL eq_flags got %b%b%b want 010", o.mayor, o.igual, o.menor); end
        idle_cycles(2);
    endtask

    task automatic test_stall;
        bit got; res_t e, o;
        drive_cmp(4'b0011, 4'b1000, 8'b0000_1010);
        fetch(got, e, o);
        checks++; if (!got) begin errors++; $display("FAIL stall_timeout got no done want done"); end
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL stall_latency got cyc %0d want %0d", o.cyc, e.cyc); end
        checks++; if ({o.mayor, o.igual, o.menor} !== 3'b001)
            begin errors++; $display("FAIL stall_flags got %b%b%b want 001", o.mayor, o.igual, o.menor); end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid;
        bit got; res_t e, o;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if ({bus.busy, bus.mayor, bus.igual, bus.menor} !== 4'b1000)
            begin errors++; $display("FAIL shift_outputs busy/flags got %b%b%b%b want 1000", bus.busy, bus.mayor, bus.igual, bus.menor); end
        for (int unsigned i = 0; i < 2; i++) begin
            bus.bit_valid = 1'b1; bus.bit_x = 1'b1; bus.bit_y = 1'b1;
            @(negedge clk);
        end
        bus.bit_valid = 1'b0;
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        checks++; if ({bus.busy, bus.done, bus.mayor, bus.igual, bus.menor} !== 5'b00000)
            begin errors++; $display("FAIL midrst_outputs got %b%b%b%b%b want 00000", bus.busy, bus.done, bus.mayor, bus.igual, bus.menor); end
        idle_cycles(6);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_nodone got %0d pulses want 0", obs_q.size()); end
        drive_cmp(4'b1111, 4'b1111, 8'h00);
        fetch(got, e, o);
        checks++; if (!got) begin errors++; $display("FAIL midrst_timeout got no done want done"); end
        checks++; if (o.cyc !== e.cyc) begin errors++; $display("FAIL midrst_latency got cyc %0d want %0d", o.cyc, e.cyc); end
        checks++; if ({o.mayor, o.igual, o.menor} !== 3'b010)
            begin errors++; $display("FAIL midrst_flags got %b%b%b want 010", o.mayor, o.igual, o.menor); end
        idle_cycles(2);
    endtask

    task automatic test_back_to_back;
        bit got1, got2; res_t e1, o1, e2, o2;
        drive_cmp(4'b1000, 4'b0111, 8'h00);
        drive_cmp(4'b0000, 4'b0001, 8'h00);
        fetch(got1, e1, o1);
        fetch(got2, e2, o2);
        checks++; if (!(got1 && got2)) begin errors++; $display("FAIL b2b_timeout got %0d%0d want 11", got1, got2); end
        checks++; if (o1.cyc !== e1.cyc) begin errors++; $display("FAIL b2b_lat1 got cyc %0d want %0d", o1.cyc, e1.cyc); end
        checks++; if (o2.cyc !== e2.cyc) begin errors++; $display("FAIL b2b_lat2 got cyc %0d want %0d", o2.cyc, e2.cyc); end
        checks++; if ({o1.mayor, o1.igual, o1.menor} !== 3'b100)
            begin errors++; $display("FAIL b2b_flags1 got %b%b%b want 100", o1.mayor, o1.igual, o1.menor); end
        checks++; if ({o2.mayor, o2.igual, o2.menor} !== 3'b001)
            begin errors++; $display("FAIL b2b_flags2 got %b%b%b want 001", o2.mayor, o2.igual, o2.menor); end
        if (!EARLY) begin
            checks++; if (o2.cyc - o1.cyc !== N + 1)
                begin errors++; $display("FAIL b2b_spacing got %0d want %0d", o2.cyc - o1.cyc, N + 1); end
        end
        idle_cycles(2);
    endtask

    task automatic test_pulse_width;
        checks++; if (max_run !== 1) begin errors++; $display("FAIL done_width got %0d cycles want 1", max_run); end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_x     = 1'b0;
        bus.bit_y     = 1'b0;
        @(negedge clk);
        test_reset;
        test_greater;
        test_equal;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        test_pulse_width;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
